// File: rtl/sad_pkg.sv
// Shared helpers and constants for the SAD block engine: width derivation and the
// all-ones initial value of the running minimum.
package sad_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if (n > (32'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

  // Wide enough to hold LANES*ROWS maximal pixel differences without overflow.
  function automatic int unsigned sad_width(input int unsigned pix_w, input int unsigned lanes,
                                            input int unsigned rows);
    return pix_w + clog2(lanes * rows);
  endfunction

  localparam int unsigned MIN_INIT_MAX_W = 64;
  localparam logic [MIN_INIT_MAX_W-1:0] MIN_INIT = '1;

endpackage

// File: rtl/sad_absdiff_lane.sv
// One window row against one frame word: registered per-lane unsigned absolute differences.
module sad_absdiff_lane #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                   Clk,
  input  logic                   en,
  input  logic [LANES*PIX_W-1:0] win_row,
  input  logic [LANES*PIX_W-1:0] frm_word,
  output logic [LANES*PIX_W-1:0] diff
);

  logic [LANES*PIX_W-1:0] diff_d;

  always_comb begin
    diff_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (win_row[l*PIX_W +: PIX_W] >= frm_word[l*PIX_W +: PIX_W]) begin
        diff_d[l*PIX_W +: PIX_W] = win_row[l*PIX_W +: PIX_W] - frm_word[l*PIX_W +: PIX_W];
      end else begin
        diff_d[l*PIX_W +: PIX_W] = frm_word[l*PIX_W +: PIX_W] - win_row[l*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (en) diff <= diff_d;
  end

endmodule

// File: rtl/sad_block_engine.sv
// Streaming block SAD engine: ROWS-row window vs sliding frame block, two-stage pipeline.
// Optional running-minimum tracker is built only when SAD_MIN_TRACK_EN is defined.
module sad_block_engine
  import sad_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned IDX_W = 16,
  localparam int unsigned SAD_W = sad_width(PIX_W, LANES, ROWS)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   win_valid,
  input  logic [LANES*PIX_W-1:0] win_data,
  input  logic                   frm_valid,
  output logic                   frm_ready,
  input  logic [LANES*PIX_W-1:0] frm_data,
  output logic                   sad_valid,
  output logic [SAD_W-1:0]       sad_value,
  output logic [IDX_W-1:0]       sad_index,
  output logic [SAD_W-1:0]       min_value,
  output logic [IDX_W-1:0]       min_index
);

  localparam int unsigned WORD_W = LANES * PIX_W;
  localparam int unsigned PTR_W  = (ROWS > 1) ? clog2(ROWS) : 1;
  localparam int unsigned FILL_W = clog2(ROWS + 1);
  localparam logic [PTR_W-1:0]  LAST_ROW    = PTR_W'(ROWS - 1);
  localparam logic [FILL_W-1:0] FULL_FILL   = FILL_W'(ROWS);
  localparam logic [FILL_W-1:0] FILL_LAUNCH = FILL_W'(ROWS - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX     = '1;
  localparam logic [SAD_W-1:0]  MIN_ONES    = MIN_INIT[SAD_W-1:0];

  logic [WORD_W-1:0] win_q [ROWS];
  logic [WORD_W-1:0] frm_q [ROWS];
  logic [WORD_W-1:0] diff  [ROWS];
  logic [PTR_W-1:0]  row_ptr_q;
  logic              win_full_q;
  logic [FILL_W-1:0] fill_q;
  logic              cmp_q, s1_valid_q, s2_valid_q;
  logic [IDX_W-1:0]  idx_q, sad_index_q;
  logic [SAD_W-1:0]  sad_value_q, sum;
  logic              win_we, accept, launch;

  assign win_we    = win_valid && !clear && !Reset;
  assign frm_ready = win_full_q && !win_valid && !clear;
  assign accept    = frm_valid && frm_ready && !Reset;
  assign launch    = accept && (fill_q >= FILL_LAUNCH);

  // Data registers are deliberately not reset.
  always_ff @(posedge Clk) begin
    if (win_we) win_q[row_ptr_q] <= win_data;
    if (accept) begin
      for (int r = 0; r < ROWS - 1; r++) frm_q[r] <= frm_q[r+1];
      frm_q[ROWS-1] <= frm_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_ptr_q   <= '0;
      win_full_q  <= 1'b0;
      fill_q      <= '0;
      cmp_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      idx_q       <= '0;
      sad_index_q <= '0;
      sad_value_q <= '0;
    end else begin
      if (win_we) begin
        row_ptr_q <= (row_ptr_q == LAST_ROW) ? '0 : row_ptr_q + 1'b1;
        if (row_ptr_q == LAST_ROW) win_full_q <= 1'b1;
      end
      if (clear) begin
        fill_q <= '0;
      end else if (win_we && fill_q == FULL_FILL) begin
        fill_q <= '0;
      end else if (accept && fill_q != FULL_FILL) begin
        fill_q <= fill_q + 1'b1;
      end
      // cmp_q marks a fresh full block in frm_q; stage 1 samples it one edge later.
      cmp_q      <= launch;
      s1_valid_q <= cmp_q && !clear;
      s2_valid_q <= s1_valid_q && !clear;
      if (s1_valid_q) sad_value_q <= sum;
      if (clear) begin
        idx_q <= '0;
      end else if (s1_valid_q) begin
        sad_index_q <= idx_q;
        if (idx_q != IDX_MAX) idx_q <= idx_q + 1'b1;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    sad_absdiff_lane #(
      .PIX_W (PIX_W),
      .LANES (LANES)
    ) u_lane (
      .Clk      (Clk),
      .en       (cmp_q),
      .win_row  (win_q[r]),
      .frm_word (frm_q[r]),
      .diff     (diff[r])
    );
  end

  always_comb begin
    sum = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int l = 0; l < LANES; l++) begin
        sum = sum + SAD_W'(diff[r][l*PIX_W +: PIX_W]);
      end
    end
  end

  assign sad_valid = s2_valid_q;
  assign sad_value = sad_value_q;
  assign sad_index = sad_index_q;

`ifdef SAD_MIN_TRACK_EN
  logic [SAD_W-1:0] min_value_q;
  logic [IDX_W-1:0] min_index_q;

  // Strict less-than keeps the earliest index on ties.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      min_value_q <= MIN_ONES;
      min_index_q <= '0;
    end else if (s2_valid_q && (sad_value_q < min_value_q)) begin
      min_value_q <= sad_value_q;
      min_index_q <= sad_index_q;
    end
  end

  assign min_value = min_value_q;
  assign min_index = min_index_q;
`else
  assign min_value = MIN_ONES;
  assign min_index = '0;
`endif

endmodule

// File: doc/sad_block_engine.md
SAD_BLOCK_ENGINE -- requirements
Module: sad_block_engine

Interface
REQ-001 The module SHALL have parameter PIX_W, default 8, meaning unsigned pixel width in bits.
REQ-002 The module SHALL have parameter LANES, default 4, meaning pixels per data word.
REQ-003 The module SHALL have parameter ROWS, default 4, meaning words (rows) per block compare.
REQ-004 The module SHALL have parameter IDX_W, default 16, meaning width of the position index.
REQ-005 The module SHALL derive localparam SAD_W = PIX_W + clog2(LANES*ROWS), which is 12 by default.
REQ-006 The module SHALL have port Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port clear, input, 1 bit: restarts the frame fill, index and minimum; the window is kept.
REQ-009 The module SHALL have port win_valid, input, 1 bit: loads one window row this cycle.
REQ-010 The module SHALL have port win_data, input, LANES*PIX_W bits: window row; lane 0 is in the LSBs.
REQ-011 The module SHALL have port frm_valid, input, 1 bit: a frame word is offered.
REQ-012 The module SHALL have port frm_ready, output, 1 bit: a frame word is accepted when frm_valid && frm_ready.
REQ-013 The module SHALL have port frm_data, input, LANES*PIX_W bits: frame word.
REQ-014 The module SHALL have port sad_valid, output, 1 bit: sad_value and sad_index are valid this cycle.
REQ-015 The module SHALL have port sad_value, output, SAD_W bits: block SAD.
REQ-016 The module SHALL have port sad_index, output, IDX_W bits: position number of this SAD.
REQ-017 The module SHALL have ports min_value (SAD_W bits) and min_index (IDX_W bits), both outputs: running minimum and its position.

Function
REQ-018 The window SHALL be ROWS registered rows, written in order through a row pointer on win_valid; the pointer wraps to 0 after row ROWS-1; win_full is set after ROWS writes.
REQ-019 frm_ready SHALL equal win_full && !win_valid && !clear, so a window write or a clear blocks frame acceptance in that cycle.
REQ-020 Each accepted frame word SHALL shift into a ROWS-deep frame register, newest at slot ROWS-1; a fill counter saturates at ROWS.
REQ-021 A compare SHALL launch on each accepted word that makes or keeps fill == ROWS; window row r is compared against frame slot r.
REQ-022 Stage 1 SHALL register all ROWS*LANES absolute differences |w - f|, each PIX_W bits unsigned.
REQ-023 Stage 2 SHALL register the adder-tree sum into sad_value; the sum has no overflow by construction of SAD_W.
REQ-024 sad_valid SHALL assert exactly 2 cycles after the accepting edge; one result SHALL issue per accepted word with no bubbles.
REQ-025 sad_index SHALL start at 0 and increment per result, saturating at 2^IDX_W-1.
REQ-026 A window write while fill == ROWS SHALL reset fill to 0; results already in the pipeline SHALL still complete.
REQ-027 clear SHALL zero the fill count and the index, squash the in-flight stage-1 and stage-2 valids, and reset the minimum.

Reset
REQ-028 On Reset, all valids, fill count, row pointer, win_full and index SHALL go to 0, and sad_value SHALL go to 0.
REQ-029 On Reset, min_value SHALL go to all-ones and min_index SHALL go to 0; the window and frame data registers are not reset.
REQ-030 Reset SHALL take priority over clear, and clear SHALL take priority over win_valid and frm_valid.

Configuration
REQ-031 With SAD_MIN_TRACK_EN defined, the minimum SHALL update in the cycle after sad_valid when sad_value < min_value (strictly less, so a tie keeps the earlier index).
REQ-032 Without SAD_MIN_TRACK_EN, min_value SHALL be held at all-ones, min_index SHALL be held at 0, and no comparator logic SHALL be synthesised.

Structure
REQ-033 A shared package sad_pkg SHALL hold the clog2 function, the SAD_W derivation and the MIN_INIT constant (all-ones).
REQ-034 A sub-module sad_absdiff_lane SHALL perform a registered LANES-wide absolute difference, instantiated ROWS times.

Verification
REQ-035 Load 4 window rows of 0x10101010 and stream 4 frame words of 0x10101010: exactly 1 sad_valid with sad_value=0 and sad_index=0, 2 cycles after the 4th word.
REQ-036 Use window all 0x00 and frame all 0xFFFFFFFF: sad_value=16*255=4080, which is the maximum and SHALL NOT overflow 12 bits.
REQ-037 Stream 10 back-to-back words: 7 consecutive sad_valid pulses with indices 0..6 and no gaps.
REQ-038 Produce SADs 50, 20, 20, 30 (SAD_MIN_TRACK_EN defined): min_value=20 and min_index=1.
REQ-039 Assert clear in the cycle after word 4 is accepted: no sad_valid; refill with 4 words gives sad_index=0 and min_value=0xFFF.
REQ-040 Assert win_valid and frm_valid in the same cycle: frm_ready=0, the frame word is not consumed and the fill count is unchanged.
